codec_intf: RTL and testbench

Serial codec interface sitting on both sides of the EQ engine. It generates the codec clocks (MCLK/SCLK/LRCLK) and deserializes left-justified 16-bit ADC data into parallel `lft_in`/`rht_in` words with a one-cycle `valid` strobe (feeds the EQ engine). It also serializes the EQ engine's `lft_out`/`rht_out` back to the codec DAC. A startup FSM holds off `valid` and drives silence until the codec has seen a configurable number of full frames.

---
 rtl/eq_pkg.sv | 12 +
 rtl/codec_clk_gen.sv | 38 +++
 rtl/codec_intf.sv | 62 ++++++
 tb/tb_codec_intf.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/eq_pkg.sv
// eq_pkg: shared widths, codec frame decode constants and codec FSM states
package eq_pkg;
  localparam int SMPL_W = 16;
  localparam int CNT_W = 10;
  localparam logic [4:0] C_RX = 5'h0F;
  localparam logic [4:0] C_TX = 5'h1F;
  localparam logic [CNT_W-1:0] C_LFT_END = 10'h1EF;
  localparam logic [CNT_W-1:0] C_RHT_END = 10'h3EF;
  localparam logic [CNT_W-1:0] C_HALF_END = 10'h1FF;
  localparam logic [CNT_W-1:0] C_FRM_END = 10'h3FF;
  typedef enum logic {WAIT, RUN} codec_state_t;
endpackage

// File: rtl/codec_clk_gen.sv
// codec_clk_gen: frame counter, registered codec clocks and frame-position strobes
module codec_clk_gen
  import eq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  output logic [CNT_W-1:0] cnt,
  output logic             MCLK,
  output logic             SCLK,
  output logic             LRCLK,
  output logic             rx_smpl,
  output logic             tx_shft,
  output logic             lft_ld,
  output logic             rht_ld,
  output logic             frm_end
);
  logic [CNT_W-1:0] cnt_nxt;
  assign cnt_nxt = cnt + CNT_W'(1);
  // clocks register the next count so they track cnt in the same cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      MCLK <= 1'b0;
      SCLK <= 1'b0;
      LRCLK <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      MCLK <= cnt_nxt[1];
      SCLK <= cnt_nxt[4];
      LRCLK <= cnt_nxt[9];
    end
  end
  assign rx_smpl = cnt[4:0] == C_RX;
  assign tx_shft = cnt[4:0] == C_TX && cnt[8:5] != 4'hF;
  assign lft_ld = cnt == C_LFT_END;
  assign rht_ld = cnt == C_RHT_END;
  assign frm_end = cnt == C_FRM_END;
endmodule

// File: rtl/codec_intf.sv
// codec_intf: codec clock generation, left-justified ADC deserializer and DAC serializer
// with a startup hold-off that suppresses valid and silences the DAC for the first frames
module codec_intf
  import eq_pkg::*;
#(
  parameter int STARTUP_FRAMES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     SDout,
  input  logic signed [SMPL_W-1:0] lft_out,
  input  logic signed [SMPL_W-1:0] rht_out,
  output logic                     MCLK,
  output logic                     SCLK,
  output logic                     LRCLK,
  output logic                     SDin,
  output logic signed [SMPL_W-1:0] lft_in,
  output logic signed [SMPL_W-1:0] rht_in,
  output logic                     valid
);
  logic [CNT_W-1:0] cnt;
  logic rx_smpl, tx_shft, lft_ld, rht_ld, frm_end, half_end, nxt_run;
  logic [3:0] frm_cnt;
  logic [SMPL_W-1:0] rx, rx_nxt, hold, tx, rbuf;
  codec_state_t state;
  codec_clk_gen u_clk (
    .clk(clk), .rst_n(rst_n), .cnt(cnt), .MCLK(MCLK), .SCLK(SCLK), .LRCLK(LRCLK),
    .rx_smpl(rx_smpl), .tx_shft(tx_shft), .lft_ld(lft_ld), .rht_ld(rht_ld), .frm_end(frm_end)
  );
  assign half_end = cnt == C_HALF_END;
  assign rx_nxt = {rx[SMPL_W-2:0], SDout};
  assign nxt_run = state == RUN || (frm_end && frm_cnt == 4'(STARTUP_FRAMES - 1));
  assign SDin = tx[SMPL_W-1];
  // holding registers take rx_nxt so the bit sampled on the same edge is included
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= WAIT;
      frm_cnt <= '0;
      rx <= '0;
      hold <= '0;
      tx <= '0;
      rbuf <= '0;
      lft_in <= '0;
      rht_in <= '0;
      valid <= 1'b0;
    end else begin
      state <= nxt_run ? RUN : WAIT;
      if (frm_end && state == WAIT) frm_cnt <= frm_cnt + 4'd1;
      if (rx_smpl) rx <= rx_nxt;
      if (lft_ld) hold <= rx_nxt;
      valid <= rht_ld && state == RUN;
      if (rht_ld && state == RUN) begin
        lft_in <= hold;
        rht_in <= rx_nxt;
      end
      tx <= frm_end ? (nxt_run ? lft_out : '0) :
            half_end ? (state == RUN ? rbuf : '0) :
            tx_shft ? tx << 1 : tx;
      if (frm_end) rbuf <= nxt_run ? rht_out : '0;
    end
  end
endmodule

// File: tb/tb_codec_intf.sv
// tb_codec_intf: codec-side model driving SDout, decoding SDin on SCLK rise, and checking
// clocks, valid timing and captured samples against frame-level expectations
module tb_codec_intf;
  localparam int SF = 2;
  logic clk = 1'b0, rst_n = 1'b0, SDout = 1'b0;
  logic [15:0] lft_out = '0, rht_out = '0;
  logic MCLK, SCLK, LRCLK, SDin, valid;
  logic [15:0] lft_in, rht_in;
  int cyc, n_cmp, n_bad, first_v;
  logic [15:0] adc_l[32], adc_r[32], tx_l[32], tx_r[32], dec_l[32], dec_r[32];
  logic [15:0] dec, exp_lin, exp_rin, first_new;
  typedef struct { int cyc; logic [3:0] exp; } vec_t;
  vec_t tv[14];

  codec_intf #(.STARTUP_FRAMES(SF)) dut (
    .clk(clk), .rst_n(rst_n), .SDout(SDout), .lft_out(lft_out), .rht_out(rht_out),
    .MCLK(MCLK), .SCLK(SCLK), .LRCLK(LRCLK), .SDin(SDin),
    .lft_in(lft_in), .rht_in(rht_in), .valid(valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h want %h", name, cyc, act, exp);
    end
  endtask

  task automatic init_model();
    cyc = 0;
    dec = '0;
    exp_lin = '0;
    exp_rin = '0;
    for (int i = 0; i < 32; i++) begin
      adc_l[i] = i < 4 ? 16'h8001 : 16'($urandom);
      adc_r[i] = i < 4 ? 16'h7FFE : 16'($urandom);
      tx_l[i] = '0;
      tx_r[i] = '0;
      dec_l[i] = '0;
      dec_r[i] = '0;
    end
  endtask

  // codec presents bit (pos within half / 32) of the current half-frame word, MSB first
  task automatic drive();
    int c = cyc % 1024;
    int f = cyc / 1024;
    int idx = (c % 512) / 32;
    logic [15:0] w;
    w = c >= 512 ? adc_r[f] : adc_l[f];
    SDout = w[15-idx];
    if (c == 512 && f >= 3) begin
      lft_out = 16'($urandom);
      rht_out = 16'($urandom);
      if (f == 3) first_new = lft_out;
    end
  endtask

  task automatic check_cycle();
    logic [9:0] c = 10'(cyc % 1024);
    int f = cyc / 1024;
    logic exp_v = c == 10'd1008 && f >= SF;
    if (exp_v) begin
      exp_lin = adc_l[f];
      exp_rin = adc_r[f];
    end
    chk("valid", 32'(valid), 32'(exp_v));
    chk("clocks", 32'({MCLK, SCLK, LRCLK}), 32'({c[1], c[4], c[9]}));
    chk("lft_rht_in", {lft_in, rht_in}, {exp_lin, exp_rin});
    if (c[4:0] == 5'd16) begin
      dec = {dec[14:0], SDin};
      if (c == 10'd496) begin
        dec_l[f] = dec;
        chk("sdin_left", 32'(dec), 32'(tx_l[f]));
      end
      if (c == 10'd1008) begin
        dec_r[f] = dec;
        chk("sdin_right", 32'(dec), 32'(tx_r[f]));
      end
    end
  endtask

  task automatic step();
    int f = cyc / 1024;
    if (cyc % 1024 == 1023) begin
      tx_l[f+1] = f + 1 >= SF ? lft_out : 16'h0;
      tx_r[f+1] = f + 1 >= SF ? rht_out : 16'h0;
    end
    @(posedge clk);
    #1;
    cyc++;
    drive();
    check_cycle();
  endtask

  task automatic reset_for(input int n);
    rst_n = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      chk("rst_ctl", 32'({MCLK, SCLK, LRCLK, SDin, valid}), 32'h0);
      chk("rst_data", {lft_in, rht_in}, 32'h0);
    end
    rst_n = 1'b1;
    init_model();
    drive();
    check_cycle();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    first_new = '0;
    tv[0] = '{0, 4'b0000};    tv[1] = '{1, 4'b0000};    tv[2] = '{2, 4'b1000};
    tv[3] = '{4, 4'b0000};    tv[4] = '{16, 4'b0100};   tv[5] = '{32, 4'b0000};
    tv[6] = '{512, 4'b0010};  tv[7] = '{1008, 4'b0110}; tv[8] = '{2032, 4'b0110};
    tv[9] = '{3055, 4'b1010}; tv[10] = '{3056, 4'b0111}; tv[11] = '{3057, 4'b0110};
    tv[12] = '{4080, 4'b0111}; tv[13] = '{5104, 4'b0111};
    lft_out = 16'hA5C3;
    rht_out = 16'h0F0F;
    reset_for(3);
    for (int i = 0; i < 14; i++) begin
      while (cyc < tv[i].cyc) step();
      chk("vector", 32'({MCLK, SCLK, LRCLK, valid}), 32'(tv[i].exp));
      if (tv[i].cyc == 3056) chk("first_capture", {lft_in, rht_in}, 32'h8001_7FFE);
    end
    while (cyc < 5 * 1024 + 'h2A0) step();
    chk("dac_silent_l1", 32'(dec_l[1]), 32'h0);
    chk("dac_silent_r1", 32'(dec_r[1]), 32'h0);
    chk("dac_first_l", 32'(dec_l[2]), 32'hA5C3);
    chk("dac_first_r", 32'(dec_r[2]), 32'h0F0F);
    chk("dac_hold_l3", 32'(dec_l[3]), 32'hA5C3);
    chk("dac_new_l4", 32'(dec_l[4]), 32'(first_new));
    lft_out = 16'hA5C3;
    rht_out = 16'h0F0F;
    reset_for(3);
    first_v = -1;
    while (cyc < 4100) begin
      step();
      if (valid && first_v < 0) first_v = cyc;
    end
    chk("first_valid_after_reset", 32'(first_v), 32'd3056);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
